// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data SRAM arbiter.
// Response owner encoding and word-size helpers.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_e;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, req[0]=instr, req[1]=data.
// Ports: clk_i, rst_ni, req_i[1:0] in; gnt_o[1:0] out (combinational).
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1 = last grant went to data, so instr wins the next tie
  logic r_last_d;

  assign gnt_o[0] = req_i[0] & (~req_i[1] | r_last_d);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~r_last_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_d <= 1'b1;
    end else if (|gnt_o) begin
      r_last_d <= gnt_o[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 1-cycle-latency SRAM between fetch and data ports.
// Ports: instr_*/data_* core req/gnt/rvalid ports, mem_* SRAM side, oob_o/clr_oob_i, contention_cnt_o.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MEM_ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      instr_req_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  input  logic                      data_we_i,
  input  logic [DATA_WIDTH/8-1:0]   data_be_i,
  input  logic [ADDR_WIDTH-1:0]     data_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      oob_o,
  input  logic                      clr_oob_i,
  output logic [CNT_WIDTH-1:0]      contention_cnt_o
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_any;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_inr;
  logic                  w_dsel;
  logic                  w_unused;

  owner_e                r_owner;
  logic                  r_rsp_oob;
  logic                  r_oob;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_req = {data_req_i, instr_req_i};

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (w_req),
    .gnt_o (w_gnt)
  );

  assign instr_gnt_o = w_gnt[0];
  assign data_gnt_o  = w_gnt[1];
  assign w_any       = |w_gnt;

  assign w_addr = w_gnt[1] ? data_addr_i : instr_addr_i;
  assign w_off  = w_addr - BASE_ADDR;
  // wrap-around below BASE_ADDR lands in the high bits, so it reads as out of range
  assign w_inr  = (w_off[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == '0);
  assign w_dsel = w_gnt[1] & w_inr;
  // byte offset within a word is ignored
  assign w_unused = ^w_off[1:0];

  assign mem_en_o    = w_any & w_inr;
  assign mem_we_o    = w_dsel & data_we_i;
  assign mem_be_o    = w_dsel ? data_be_i : {BPW{1'b0}};
  assign mem_addr_o  = mem_en_o ? w_off[MEM_ADDR_WIDTH+1:2] : '0;
  assign mem_wdata_o = data_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner   <= OWN_NONE;
      r_rsp_oob <= 1'b0;
    end else begin
      unique case (1'b1)
        w_gnt[0]: r_owner <= OWN_INSTR;
        w_gnt[1]: r_owner <= OWN_DATA;
        default:  r_owner <= OWN_NONE;
      endcase
      r_rsp_oob <= w_any & ~w_inr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_oob <= 1'b0;
    end else if (w_any & ~w_inr) begin
      r_oob <= 1'b1;
    end else if (clr_oob_i) begin
      r_oob <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (instr_req_i & data_req_i & ~&r_cnt) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // rdata is zero when idle or when the access fell outside the SRAM
  assign w_rdata = (r_owner != OWN_NONE && !r_rsp_oob) ? mem_rdata_i : '0;

  assign instr_rvalid_o   = (r_owner == OWN_INSTR);
  assign data_rvalid_o    = (r_owner == OWN_DATA);
  assign instr_rdata_o    = w_rdata;
  assign data_rdata_o     = w_rdata;
  assign oob_o            = r_oob;
  assign contention_cnt_o = r_cnt;

endmodule
